pcie_tlp_arb: RTL and testbench

Credit-aware round-robin arbiter that shares the single 1024-bit TLP link into the data link layer among three traffic classes: posted writes (AW/W path), non-posted read requests (AR path) and completions. Each class holds a flow-control credit counter. Counters are replenished by credit-update DLLPs from the receiver and consumed one credit per granted TLP. Sits between the TLP header/payload builders and the TX link, and is enabled by the SAL_CFG start bit.

---
 rtl/pcie_pkg.sv | 28 ++
 rtl/pcie_tlp_arb_if.sv | 34 +++
 rtl/pcie_fc_credit.sv | 36 +++
 rtl/pcie_tlp_arb.sv | 114 +++++++++++
 tb/tb_pcie_tlp_arb.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_pkg.sv
// Shared types and constants for the PCIe TLP credit arbiter.
// Class encoding matches the tlp_class_o / fc_upd_class_i wire encoding.
// Default sizes are used as parameter defaults by the arbiter and interface.
package pcie_pkg;

  typedef enum logic [1:0] {
    CLS_P    = 2'd0,
    CLS_NP   = 2'd1,
    CLS_CPL  = 2'd2,
    CLS_NONE = 2'd3
  } tlp_class_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  localparam int NUM_CLASS        = 3;
  localparam int DEF_DATA_W       = 1024;
  localparam int DEF_CREDIT_W     = 8;
  localparam int DEF_INIT_CREDITS = 16;

  // Round-robin successor of a class index, wrapping CPL back to P.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/pcie_tlp_arb_if.sv
// Bundles the request, TX link, credit-update and credit-status signals.
// master = TLP builders / link / DLLP side, slave = the arbiter.
// Pure wiring, no logic.
interface pcie_tlp_arb_if
  import pcie_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CREDIT_W = DEF_CREDIT_W
);
  logic                      arb_en_i;
  logic [NUM_CLASS-1:0]      req_valid_i;
  logic [NUM_CLASS*DATA_W-1:0] req_data_i;
  logic [NUM_CLASS-1:0]      req_ready_o;
  logic [DATA_W-1:0]         tlp_data_o;
  logic                      tlp_valid_o;
  logic                      tlp_ready_i;
  logic [1:0]                tlp_class_o;
  logic                      fc_upd_valid_i;
  logic [1:0]                fc_upd_class_i;
  logic [CREDIT_W-1:0]       fc_upd_cnt_i;
  logic [NUM_CLASS*CREDIT_W-1:0] credit_o;

  modport master (
    output arb_en_i, req_valid_i, req_data_i, tlp_ready_i,
           fc_upd_valid_i, fc_upd_class_i, fc_upd_cnt_i,
    input  req_ready_o, tlp_data_o, tlp_valid_o, tlp_class_o, credit_o
  );

  modport slave (
    input  arb_en_i, req_valid_i, req_data_i, tlp_ready_i,
           fc_upd_valid_i, fc_upd_class_i, fc_upd_cnt_i,
    output req_ready_o, tlp_data_o, tlp_valid_o, tlp_class_o, credit_o
  );
endinterface

// File: rtl/pcie_fc_credit.sv
// Saturating flow-control credit counter for one traffic class.
// Latency: consume/return take effect on the next clock edge.
// Backpressure: none; the caller only consumes when the count is non-zero.
module pcie_fc_credit #(
  parameter int CREDIT_W     = 8,
  parameter int INIT_CREDITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                consume,
  input  logic                ret_vld,
  input  logic [CREDIT_W-1:0] ret_cnt,
  output logic [CREDIT_W-1:0] credit
);
  localparam logic [CREDIT_W:0] MAX_CNT = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W:0] ONE     = {{CREDIT_W{1'b0}}, 1'b1};

  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W:0]   sum;

  // One guard bit holds credit + return before the -1, so saturation sees the true total.
  always_comb begin
    sum = {1'b0, credit_q};
    if (ret_vld) sum = sum + {1'b0, ret_cnt};
    if (consume) sum = sum - ONE;
  end

  // Counter register, reloaded on reset and clamped at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n)             credit_q <= CREDIT_W'(INIT_CREDITS);
    else if (sum > MAX_CNT) credit_q <= MAX_CNT[CREDIT_W-1:0];
    else                    credit_q <= sum[CREDIT_W-1:0];
  end

  assign credit = credit_q;
endmodule

// File: rtl/pcie_tlp_arb.sv
// Credit-aware round-robin arbiter of P/NP/CPL TLPs onto one TX link.
// Latency: a TLP granted in cycle N is presented on the link in cycle N+1.
// Backpressure: one-entry output register; a stalled link withholds all req_ready_o.
module pcie_tlp_arb
  import pcie_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CREDIT_W     = DEF_CREDIT_W,
  parameter int INIT_CREDITS = DEF_INIT_CREDITS
) (
  input logic           clk,
  input logic           rst_n,
  pcie_tlp_arb_if.slave bus
);
  logic [CREDIT_W-1:0]  credit [NUM_CLASS];
  logic [NUM_CLASS-1:0] elig;
  logic [NUM_CLASS-1:0] ready;
  logic [NUM_CLASS-1:0] grant;
  logic                 grant_any;
  logic                 win_found;
  logic [1:0]           win_idx;
  logic                 slot_free;
  logic [1:0]           rr_q;
  out_state_t           state_q, state_d;
  logic [DATA_W-1:0]    data_q;
  tlp_class_t           cls_q;

  // A class competes only while it has both a request and a credit.
  always_comb begin
    for (int i = 0; i < NUM_CLASS; i++)
      elig[i] = bus.req_valid_i[i] && (credit[i] != '0);
  end

  // Round-robin search from the pointer upward; zero-credit classes are simply passed over.
  always_comb begin
    logic [2:0] sum;
    logic [1:0] idx;
    win_found = 1'b0;
    win_idx   = 2'd0;
    sum       = 3'd0;
    idx       = 2'd0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      sum = {1'b0, rr_q} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      idx = sum[1:0];
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // The output register can take a TLP when empty or when the link drains it this cycle.
  assign slot_free = (state_q == ST_EMPTY) || bus.tlp_ready_i;

  // Accept strobe to the winner only; held low during reset and while disabled.
  always_comb begin
    ready = '0;
    if (rst_n && bus.arb_en_i && slot_free && win_found) ready[win_idx] = 1'b1;
  end

  assign grant     = bus.req_valid_i & ready;
  assign grant_any = |grant;

  // Output-stage state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Fill on grant, empty when the link takes the TLP with nothing behind it.
  always_comb begin
    state_d = state_q;
    if (grant_any)                                   state_d = ST_FULL;
    else if (state_q == ST_FULL && bus.tlp_ready_i)  state_d = ST_EMPTY;
  end

  // Output payload/class register, loaded only on a grant so a stalled TLP stays put.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      cls_q  <= CLS_P;
    end else if (grant_any) begin
      data_q <= bus.req_data_i[win_idx*DATA_W +: DATA_W];
      cls_q  <= tlp_class_t'(win_idx);
    end
  end

  // Pointer moves just past the class that was actually served.
  always_ff @(posedge clk) begin
    if (!rst_n)         rr_q <= 2'd0;
    else if (grant_any) rr_q <= rr_next(win_idx);
  end

  for (genvar i = 0; i < NUM_CLASS; i++) begin : g_credit
    pcie_fc_credit #(
      .CREDIT_W     (CREDIT_W),
      .INIT_CREDITS (INIT_CREDITS)
    ) u_credit (
      .clk     (clk),
      .rst_n   (rst_n),
      .consume (grant[i]),
      .ret_vld (bus.fc_upd_valid_i && (bus.fc_upd_class_i == 2'(i))),
      .ret_cnt (bus.fc_upd_cnt_i),
      .credit  (credit[i])
    );
    assign bus.credit_o[i*CREDIT_W +: CREDIT_W] = credit[i];
  end

  assign bus.req_ready_o = ready;
  assign bus.tlp_valid_o = (state_q == ST_FULL);
  assign bus.tlp_data_o  = data_q;
  assign bus.tlp_class_o = cls_q;
endmodule

// File: tb/tb_pcie_tlp_arb.sv
// Directed bench for pcie_tlp_arb: a vector table for round-robin, stall,
// enable and update behaviour, plus hand sequences for credit exhaustion,
// saturation and reset while full.
module tb_pcie_tlp_arb;
  localparam int DW = 1024;
  localparam int CW = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  pcie_tlp_arb_if #(.DATA_W(DW), .CREDIT_W(CW)) bus ();

  pcie_tlp_arb #(.DATA_W(DW), .CREDIT_W(CW), .INIT_CREDITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] vld;
    logic       rdy;
    logic       fv;
    logic [1:0] fc;
    logic [7:0] fn;
    logic [2:0] e_rdy;
    logic       e_vld;
    logic [1:0] e_cls;
    int         e_tag;
    int         c0, c1, c2;
  } vec_t;

  vec_t tbl [21];

  // 32-bit word {class, tag} replicated across the beat, so every slice is distinct.
  function automatic logic [DW-1:0] mk(input int c, input int t);
    logic [31:0] w;
    logic [1:0]  cc;
    cc = c[1:0];
    w  = {cc, t[29:0]};
    return {(DW/32){w}};
  endfunction

  function automatic vec_t v(input logic rst, en, input logic [2:0] vld, input logic rdy,
                             input logic fv, input logic [1:0] fc, input logic [7:0] fn,
                             input logic [2:0] e_rdy, input logic e_vld,
                             input logic [1:0] e_cls, input int e_tag,
                             input int c0, c1, c2);
    vec_t r;
    r.rst = rst; r.en = en; r.vld = vld; r.rdy = rdy;
    r.fv = fv; r.fc = fc; r.fn = fn;
    r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_cls = e_cls; r.e_tag = e_tag;
    r.c0 = c0; r.c1 = c1; r.c2 = c2;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, en, input logic [2:0] vld, input logic rdy,
                       input logic fv, input logic [1:0] fc, input logic [7:0] fn,
                       input int tag);
    rst_n              = rst;
    bus.arb_en_i       = en;
    bus.req_valid_i    = vld;
    bus.tlp_ready_i    = rdy;
    bus.fc_upd_valid_i = fv;
    bus.fc_upd_class_i = fc;
    bus.fc_upd_cnt_i   = fn;
    for (int c = 0; c < 3; c++) bus.req_data_i[c*DW +: DW] = mk(c, tag);
  endtask

  function automatic int cr(input int i);
    return int'(bus.credit_o[i*CW +: CW]);
  endfunction

  task automatic chk_cr(input string nm, input int c0, c1, c2);
    chk({nm, " credit0"}, cr(0), c0);
    chk({nm, " credit1"}, cr(1), c1);
    chk({nm, " credit2"}, cr(2), c2);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 8'd0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    string nm;
    errors = 0;
    checks = 0;
    drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 8'd0, 0);
    tick();
    tick();

    //           rst en  vld    rdy fv fc  fn    e_rdy  ev cls tag c0  c1  c2
    tbl[0]  = v(0, 1, 3'b111, 1, 0, 0, 0,   3'b000, 0, 0, 0,  16, 16, 16);
    tbl[1]  = v(1, 1, 3'b111, 1, 0, 0, 0,   3'b001, 0, 0, 0,  16, 16, 16);
    tbl[2]  = v(1, 1, 3'b111, 1, 0, 0, 0,   3'b010, 1, 0, 1,  15, 16, 16);
    tbl[3]  = v(1, 1, 3'b111, 1, 0, 0, 0,   3'b100, 1, 1, 2,  15, 15, 16);
    tbl[4]  = v(1, 1, 3'b111, 1, 0, 0, 0,   3'b001, 1, 2, 3,  15, 15, 15);
    tbl[5]  = v(1, 1, 3'b111, 1, 0, 0, 0,   3'b010, 1, 0, 4,  14, 15, 15);
    tbl[6]  = v(1, 1, 3'b111, 0, 0, 0, 0,   3'b000, 1, 1, 5,  14, 14, 15);
    tbl[7]  = v(1, 1, 3'b111, 0, 0, 0, 0,   3'b000, 1, 1, 5,  14, 14, 15);
    tbl[8]  = v(1, 1, 3'b111, 0, 0, 0, 0,   3'b000, 1, 1, 5,  14, 14, 15);
    tbl[9]  = v(1, 1, 3'b111, 0, 0, 0, 0,   3'b000, 1, 1, 5,  14, 14, 15);
    tbl[10] = v(1, 1, 3'b111, 0, 0, 0, 0,   3'b000, 1, 1, 5,  14, 14, 15);
    tbl[11] = v(1, 1, 3'b111, 1, 0, 0, 0,   3'b100, 1, 1, 5,  14, 14, 15);
    tbl[12] = v(1, 0, 3'b111, 1, 0, 0, 0,   3'b000, 1, 2, 11, 14, 14, 14);
    tbl[13] = v(1, 0, 3'b111, 1, 0, 0, 0,   3'b000, 0, 0, 0,  14, 14, 14);
    tbl[14] = v(1, 1, 3'b010, 0, 0, 0, 0,   3'b010, 0, 0, 0,  14, 14, 14);
    tbl[15] = v(1, 0, 3'b111, 0, 0, 0, 0,   3'b000, 1, 1, 14, 14, 13, 14);
    tbl[16] = v(1, 0, 3'b111, 1, 0, 0, 0,   3'b000, 1, 1, 14, 14, 13, 14);
    tbl[17] = v(1, 0, 3'b111, 1, 0, 0, 0,   3'b000, 0, 0, 0,  14, 13, 14);
    tbl[18] = v(1, 0, 3'b000, 1, 1, 3, 7,   3'b000, 0, 0, 0,  14, 13, 14);
    tbl[19] = v(1, 0, 3'b000, 1, 1, 1, 2,   3'b000, 0, 0, 0,  14, 13, 14);
    tbl[20] = v(1, 0, 3'b000, 1, 0, 0, 0,   3'b000, 0, 0, 0,  14, 15, 14);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].vld, tbl[i].rdy,
            tbl[i].fv, tbl[i].fc, tbl[i].fn, 100 + i);
      mid();
      nm = $sformatf("vec%0d", i);
      chk({nm, " req_ready"}, int'(bus.req_ready_o), int'(tbl[i].e_rdy));
      chk({nm, " tlp_valid"}, int'(bus.tlp_valid_o), int'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        chk({nm, " tlp_class"}, int'(bus.tlp_class_o), int'(tbl[i].e_cls));
        chk({nm, " tlp_data"}, int'(bus.tlp_data_o == mk(int'(tbl[i].e_cls), 100 + tbl[i].e_tag)), 1);
      end
      chk_cr(nm, tbl[i].c0, tbl[i].c1, tbl[i].c2);
      tick();
    end

    // P-only until its credits run out, then NP still served, then a late credit return.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 2'd0, 8'd0, i);
      mid();
      chk($sformatf("p_only%0d req_ready", i), int'(bus.req_ready_o), 1);
      tick();
    end
    drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 2'd0, 8'd0, 0);
    mid();
    chk("p_exhausted credit0", cr(0), 0);
    chk("p_exhausted req_ready", int'(bus.req_ready_o), 0);
    drive(1'b1, 1'b1, 3'b011, 1'b1, 1'b0, 2'd0, 8'd0, 0);
    mid();
    chk("np_after_p req_ready", int'(bus.req_ready_o), 2);
    tick();
    drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 2'd0, 8'd4, 0);
    mid();
    chk("upd_cycle req_ready", int'(bus.req_ready_o), 0);
    tick();
    drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 2'd0, 8'd0, 0);
    mid();
    chk("after_upd credit0", cr(0), 4);
    chk("after_upd req_ready", int'(bus.req_ready_o), 1);
    tick();
    drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 2'd0, 8'd2, 0);
    mid();
    chk("post_grant credit0", cr(0), 3);
    chk("grant_and_upd req_ready", int'(bus.req_ready_o), 1);
    tick();
    drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 2'd0, 8'd0, 0);
    mid();
    chk("grant_and_upd credit0", cr(0), 4);
    tick();

    // Saturation at 255 and ignored class 3.
    do_reset();
    drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 2'd2, 8'd234, 0);
    tick();
    mid();
    chk("sat_pre credit2", cr(2), 250);
    tick();
    drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 2'd2, 8'd10, 0);
    tick();
    mid();
    chk("sat credit2", cr(2), 255);
    tick();
    drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 2'd3, 8'd5, 0);
    tick();
    drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 2'd0, 8'd0, 0);
    mid();
    chk_cr("class3_upd", 16, 16, 255);
    tick();

    // Drain credits to 5/0/9 with a CPL left in the output register, then reset.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 2'd0, 8'd0, i);
      tick();
    end
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 2'd0, 8'd0, i);
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 2'd0, 8'd0, i);
      tick();
    end
    drive(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 0);
    mid();
    chk("pre_rst tlp_valid", int'(bus.tlp_valid_o), 1);
    chk("pre_rst tlp_class", int'(bus.tlp_class_o), 2);
    chk_cr("pre_rst", 5, 0, 9);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mid();
    chk("post_rst tlp_valid", int'(bus.tlp_valid_o), 0);
    chk("post_rst tlp_class", int'(bus.tlp_class_o), 0);
    chk("post_rst tlp_data_zero", int'(bus.tlp_data_o == '0), 1);
    chk_cr("post_rst", 16, 16, 16);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
